// File: rtl/bus_load_ctrl.sv
// ---------------------------------------------------------------------------
// bus_load_ctrl
//
// Command sequencer for a four-entry register bank. It accepts one command at
// a time and turns it into bank strobes:
//   LOAD : read a byte from memory (WAIT_STATES wait cycles), then write it
//          into register[sel] over BusOut with Wen[sel].
//   INC  : single-cycle INC[sel] strobe.
//   CLR  : single-cycle Clr[sel] strobe.
//   NOP  : single-cycle completion with no strobe.
// Each command ends with a one-cycle done pulse. Commands that arrive while
// the block is busy are ignored, not queued.
//
// Parameters
//   WAIT_STATES  memory read wait cycles, legal range 1..15
//
// Ports
//   Clk        clock, rising edge
//   RST        asynchronous active-low reset
//   cmd_valid  command request
//   cmd_ready  command accept (high only in IDLE, out of reset)
//   cmd_op     00 LOAD, 01 INC, 10 CLR, 11 NOP
//   cmd_sel    target register index 0..3
//   cmd_addr   memory address for LOAD
//   mem_addr   memory read address (0 whenever mem_rd is low)
//   mem_rd     memory read strobe
//   mem_rdata  memory read data
//   BusOut     data bus to the register bank
//   Wen        one-hot register write enable
//   INC        one-hot register increment strobe
//   Clr        one-hot register clear strobe
//   done       one-cycle command completion pulse
//
// Build option
//   BUS_HOLD_EN  when defined, BusOut keeps the last written value outside the
//                WRITE cycle; when undefined, BusOut is 0 outside WRITE.
// ---------------------------------------------------------------------------
module bus_load_ctrl #(
    parameter int WAIT_STATES = 2
) (
    input  logic       Clk,
    input  logic       RST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_sel,
    input  logic [7:0] cmd_addr,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    input  logic [7:0] mem_rdata,
    output logic [7:0] BusOut,
    output logic [3:0] Wen,
    output logic [3:0] INC,
    output logic [3:0] Clr,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        STRB  = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;

    // Counter value seen during the last READ cycle (counter starts at 0).
    localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] sel_q;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Ready is derived from the state register; gating with RST keeps it low
    // for the whole time reset is held.
    assign cmd_ready = (state == IDLE) && RST;

    // All strobes are registered: they are set on the edge that enters the
    // cycle in which they must be visible, and cleared by default on every
    // other edge, so each lasts exactly one cycle.
    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            sel_q    <= 2'd0;
            mem_rd   <= 1'b0;
            mem_addr <= 8'd0;
            BusOut   <= 8'd0;
            Wen      <= 4'd0;
            INC      <= 4'd0;
            Clr      <= 4'd0;
            done     <= 1'b0;
        end else begin
            Wen  <= 4'd0;
            INC  <= 4'd0;
            Clr  <= 4'd0;
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        sel_q <= cmd_sel;
                        case (cmd_op)
                            OP_LOAD: begin
                                state    <= READ;
                                cnt      <= 4'd0;
                                mem_rd   <= 1'b1;
                                mem_addr <= cmd_addr;
                            end
                            OP_INC: begin
                                state <= STRB;
                                INC   <= onehot(cmd_sel);
                                done  <= 1'b1;
                            end
                            OP_CLR: begin
                                state <= STRB;
                                Clr   <= onehot(cmd_sel);
                                done  <= 1'b1;
                            end
                            default: begin
                                // NOP: completes with no strobe.
                                state <= STRB;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end

                READ: begin
                    if (cnt == LAST_CNT) begin
                        // Edge ending the last wait cycle: capture the data
                        // and present it to the bank in the WRITE cycle.
                        state    <= WRITE;
                        cnt      <= 4'd0;
                        mem_rd   <= 1'b0;
                        mem_addr <= 8'd0;
                        BusOut   <= mem_rdata;
                        Wen      <= onehot(sel_q);
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                WRITE: begin
                    state <= IDLE;
`ifdef BUS_HOLD_EN
                    // BusOut keeps the value just written.
`else
                    BusOut <= 8'd0;
`endif
                end

                STRB: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_load_ctrl.sv
module tb_bus_load_ctrl;

    logic       Clk;
    logic       RST;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_sel;
    logic [7:0] cmd_addr;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic [7:0] BusOut;
    logic [3:0] Wen;
    logic [3:0] INC;
    logic [3:0] Clr;
    logic       done;

    int errors = 0;
    int checks = 0;

    // Random-phase monitor counters
    bit mon_en = 1'b0;
    int acc_cnt = 0;
    int done_cnt = 0;

`ifdef BUS_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    bus_load_ctrl #(.WAIT_STATES(2)) dut (
        .Clk       (Clk),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_sel   (cmd_sel),
        .cmd_addr  (cmd_addr),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .BusOut    (BusOut),
        .Wen       (Wen),
        .INC       (INC),
        .Clr       (Clr),
        .done      (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory model: data = address ^ 0x7A (0x20 -> 0x5A, 0x49 -> 0x33, 0x10 -> 0x6A)
    assign mem_rdata = mem_rd ? (mem_addr ^ 8'h7A) : 8'hEE;

    always @(posedge Clk) begin
        if (mon_en && cmd_valid && cmd_ready) acc_cnt++;
    end

    always @(negedge Clk) begin
        if (mon_en) begin
            checks++;
            if ($countones({Wen, INC, Clr}) > 1) begin
                errors++;
                $display("FAIL onehot_invariant got Wen=%b INC=%b Clr=%b required at most one bit", Wen, INC, Clr);
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b11; cmd_sel = 2'd0; cmd_addr = 8'd0;
        #3 RST = 1'b0;
        tick(); tick();
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b required=0", cmd_ready); end
        checks++;
        if ({Wen, INC, Clr, done, mem_rd} !== 13'd0) begin errors++;
            $display("FAIL reset_strobes got Wen=%b INC=%b Clr=%b done=%b mem_rd=%b required all 0", Wen, INC, Clr, done, mem_rd); end
        checks++;
        if (mem_addr !== 8'h00 || BusOut !== 8'h00) begin errors++;
            $display("FAIL reset_buses got mem_addr=%h BusOut=%h required 00/00", mem_addr, BusOut); end
        RST = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b required=1", cmd_ready); end
    endtask

    task automatic test_load();
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_sel = 2'd1; cmd_addr = 8'h20;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 8'h20 || cmd_ready !== 1'b0) begin errors++;
            $display("FAIL load_read1 got mem_rd=%b mem_addr=%h ready=%b required 1/20/0", mem_rd, mem_addr, cmd_ready); end
        tick();
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 8'h20 || Wen !== 4'b0000 || done !== 1'b0) begin errors++;
            $display("FAIL load_read2 got mem_rd=%b mem_addr=%h Wen=%b done=%b required 1/20/0000/0", mem_rd, mem_addr, Wen, done); end
        tick();
        checks++;
        if (Wen !== 4'b0010 || BusOut !== 8'h5A || done !== 1'b1) begin errors++;
            $display("FAIL load_write got Wen=%b BusOut=%h done=%b required 0010/5a/1", Wen, BusOut, done); end
        checks++;
        if (mem_rd !== 1'b0 || mem_addr !== 8'h00) begin errors++;
            $display("FAIL load_write_mem got mem_rd=%b mem_addr=%h required 0/00", mem_rd, mem_addr); end
        tick();
        checks++;
        if (Wen !== 4'b0000 || done !== 1'b0 || cmd_ready !== 1'b1) begin errors++;
            $display("FAIL load_idle got Wen=%b done=%b ready=%b required 0000/0/1", Wen, done, cmd_ready); end
        checks++;
        if (BusOut !== (HOLD ? 8'h5A : 8'h00)) begin errors++;
            $display("FAIL load_idle_bus got=%h required=%h", BusOut, (HOLD ? 8'h5A : 8'h00)); end
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_sel = 2'd3;
        tick();
        if (done) dones++;
        checks++;
        if (INC !== 4'b1000 || Clr !== 4'b0000 || cmd_ready !== 1'b0) begin errors++;
            $display("FAIL b2b_inc got INC=%b Clr=%b ready=%b required 1000/0000/0", INC, Clr, cmd_ready); end
        cmd_op = 2'b10; cmd_sel = 2'd0;
        tick();
        if (done) dones++;
        checks++;
        if (INC !== 4'b0000 || Clr !== 4'b0000 || cmd_ready !== 1'b1) begin errors++;
            $display("FAIL b2b_gap got INC=%b Clr=%b ready=%b required 0000/0000/1", INC, Clr, cmd_ready); end
        tick();
        if (done) dones++;
        cmd_valid = 1'b0;
        checks++;
        if (Clr !== 4'b0001 || INC !== 4'b0000) begin errors++;
            $display("FAIL b2b_clr got Clr=%b INC=%b required 0001/0000", Clr, INC); end
        tick();
        if (done) dones++;
        checks++;
        if (Clr !== 4'b0000 || dones != 2) begin errors++;
            $display("FAIL b2b_done got Clr=%b dones=%0d required 0000/2", Clr, dones); end
    endtask

    task automatic test_busy_ignore();
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_sel = 2'd0; cmd_addr = 8'h10;
        tick();
        cmd_op = 2'b01; cmd_sel = 2'd2;
        tick();
        checks++;
        if (INC !== 4'b0000 || mem_rd !== 1'b1) begin errors++;
            $display("FAIL busy_read2 got INC=%b mem_rd=%b required 0000/1", INC, mem_rd); end
        tick();
        checks++;
        if (Wen !== 4'b0001 || BusOut !== 8'h6A || INC !== 4'b0000 || done !== 1'b1) begin errors++;
            $display("FAIL busy_write got Wen=%b BusOut=%h INC=%b done=%b required 0001/6a/0000/1", Wen, BusOut, INC, done); end
        tick();
        checks++;
        if (INC !== 4'b0000 || cmd_ready !== 1'b1) begin errors++;
            $display("FAIL busy_idle got INC=%b ready=%b required 0000/1", INC, cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (INC !== 4'b0100 || done !== 1'b1) begin errors++;
            $display("FAIL busy_inc got INC=%b done=%b required 0100/1", INC, done); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        int bad;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_sel = 2'd2; cmd_addr = 8'h40;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 8'h40) begin errors++;
            $display("FAIL rstmid_read2 got mem_rd=%b mem_addr=%h required 1/40", mem_rd, mem_addr); end
        #2 RST = 1'b0;
        #1;
        checks++;
        if ({Wen, INC, Clr, done, mem_rd, cmd_ready} !== 14'd0 || mem_addr !== 8'h00 || BusOut !== 8'h00) begin errors++;
            $display("FAIL rstmid_async got Wen=%b INC=%b Clr=%b done=%b mem_rd=%b ready=%b mem_addr=%h BusOut=%h required all 0",
                     Wen, INC, Clr, done, mem_rd, cmd_ready, mem_addr, BusOut); end
        tick(); tick();
        RST = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (Wen !== 4'b0000 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++;
            $display("FAIL rstmid_no_late got bad_cycles=%0d required 0", bad); end
        cmd_valid = 1'b1; cmd_op = 2'b11;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || {Wen, INC, Clr} !== 12'd0) begin errors++;
            $display("FAIL rstmid_newcmd got done=%b strobes=%b required 1/0", done, {Wen, INC, Clr}); end
        tick();
    endtask

    task automatic test_bus_hold();
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_sel = 2'd3; cmd_addr = 8'h49;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        checks++;
        if (BusOut !== 8'h33 || Wen !== 4'b1000) begin errors++;
            $display("FAIL hold_write got BusOut=%h Wen=%b required 33/1000", BusOut, Wen); end
        tick();
        cmd_valid = 1'b1; cmd_op = 2'b11;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || {Wen, INC, Clr} !== 12'd0) begin errors++;
            $display("FAIL hold_nop got done=%b strobes=%b required 1/0", done, {Wen, INC, Clr}); end
        checks++;
        if (BusOut !== (HOLD ? 8'h33 : 8'h00)) begin errors++;
            $display("FAIL hold_bus_nop got=%h required=%h", BusOut, (HOLD ? 8'h33 : 8'h00)); end
        tick();
        checks++;
        if (BusOut !== (HOLD ? 8'h33 : 8'h00)) begin errors++;
            $display("FAIL hold_bus_idle got=%h required=%h", BusOut, (HOLD ? 8'h33 : 8'h00)); end
    endtask

    task automatic test_random();
        int waited;
        mon_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            waited = 0;
            while (!cmd_ready && waited < 40) begin
                tick();
                waited++;
            end
            if (!cmd_ready) begin
                errors++; checks++;
                $display("FAIL rand_ready_timeout got ready=%b required 1 within 40 cycles", cmd_ready);
                break;
            end
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_sel   = 2'($urandom_range(0, 3));
            cmd_addr  = 8'($urandom_range(0, 255));
            tick();
            // Busy-time noise: may or may not be accepted once IDLE returns.
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_sel   = 2'($urandom_range(0, 3));
            cmd_addr  = 8'($urandom_range(0, 255));
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        mon_en = 1'b0;
        checks++;
        if (done_cnt != acc_cnt || acc_cnt < 200) begin errors++;
            $display("FAIL rand_done_count got done=%0d accepts=%0d required equal and >=200", done_cnt, acc_cnt); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_read();
        test_bus_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
